// File: rtl/keypad_mode_ctrl_pkg.sv
// Shared types, default parameters and helpers for the keypad mode/octave controller.
package keypad_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PUBLISH,
        LOCKOUT
    } ctrl_state_t;

    localparam int DEF_NUM_MODES      = 4;
    localparam int DEF_OCT_MIN        = 0;
    localparam int DEF_OCT_MAX        = 7;
    localparam int DEF_OCT_RESET      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 100000;

    // Any value at or beyond the last mode (including forced illegal ones) wraps to 0.
    function automatic int unsigned next_mode(input int unsigned cur, input int unsigned num_modes);
        return (cur >= num_modes - 1) ? 0 : cur + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/keypad_mode_ctrl_if.sv
// Configuration bus from the keypad controller to the oscillator/mixer datapath.
interface keypad_mode_ctrl_if #(
    parameter int MW = 2,
    parameter int OW = 3
) ();
    logic [MW-1:0] mode;
    logic [OW-1:0] octave;
    logic          cfg_valid;
    logic          cfg_ready;

    modport master (output mode, output octave, output cfg_valid, input cfg_ready);
    modport slave  (input mode, input octave, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/keypad_mode_ctrl_lockout_timer.sv
// Loadable down-counter; 'last' flags the final counted cycle so the owner can leave on time.
module lockout_timer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             active,
    output logic             last
);
    logic [WIDTH-1:0] count;

    // NOTE: synchronous reset lives inside the clocked branch; the counter is
    // real state, so it uses non-blocking assignment only.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign active = (count != '0);
    assign last   = (count == WIDTH'(1));

endmodule

// File: rtl/keypad_mode_ctrl.sv
// Keypad mode/octave controller: steps registers on press pulses, publishes each
// change over a valid/ready bus, then ignores presses for a lockout window.
module keypad_mode_ctrl
    import keypad_ctrl_pkg::*;
#(
    parameter int NUM_MODES      = DEF_NUM_MODES,
    parameter int OCT_MIN        = DEF_OCT_MIN,
    parameter int OCT_MAX        = DEF_OCT_MAX,
    parameter int OCT_RESET      = DEF_OCT_RESET,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 modekey,
    input  logic                 octive_up,
    input  logic                 octive_down,
    keypad_mode_ctrl_if.master   cfg,
    output logic                 busy
);
    localparam int MW = $clog2(NUM_MODES);
    localparam int OW = $clog2(OCT_MAX + 1);
    localparam int CW = cnt_width(LOCKOUT_CYCLES);

    ctrl_state_t   state, state_next;
    logic [MW-1:0] mode_q, mode_d, mode_step;
    logic [OW-1:0] oct_q, oct_d, oct_step;
    logic          valid_q, valid_d;
    logic          timer_load, timer_active, timer_last;

    lockout_timer #(.WIDTH(CW)) u_lockout (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (timer_load),
        .load_val (CW'(LOCKOUT_CYCLES)),
        .active   (timer_active),
        .last     (timer_last)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            mode_q  <= '0;
            oct_q   <= OW'(OCT_RESET);
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            mode_q  <= mode_d;
            oct_q   <= oct_d;
            valid_q <= valid_d;
        end
    end

    // Candidate values from this cycle's pulses; a simultaneous up/down pair cancels.
    always_comb begin
        mode_step = modekey ? MW'(next_mode(32'(mode_q), NUM_MODES)) : mode_q;
        oct_step  = oct_q;
        if (octive_up && !octive_down && (oct_q < OW'(OCT_MAX))) begin
            oct_step = oct_q + OW'(1);
        end else if (octive_down && !octive_up && (oct_q > OW'(OCT_MIN))) begin
            oct_step = oct_q - OW'(1);
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        mode_d     = mode_q;
        oct_d      = oct_q;
        valid_d    = valid_q;
        timer_load = 1'b0;

        unique case (state)
            IDLE: begin
                if ((mode_step != mode_q) || (oct_step != oct_q)) begin
                    mode_d     = mode_step;
                    oct_d      = oct_step;
                    valid_d    = 1'b1;
                    state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                if (valid_q && cfg.cfg_ready) begin
                    valid_d = 1'b0;
                    if (LOCKOUT_CYCLES > 0) begin
                        timer_load = 1'b1;
                        state_next = LOCKOUT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                if (timer_last || !timer_active) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cfg.mode      = mode_q;
    assign cfg.octave    = oct_q;
    assign cfg.cfg_valid = valid_q;
    assign busy          = (state != IDLE);

endmodule
